// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio sawtooth monitor.
// The state enum, the default sample type and the saturating increment live here.
package audio_pkg;

    typedef enum logic [1:0] {
        StEmpty,
        StLearn,
        StTrain,
        StLocked
    } mon_state_t;

    localparam int unsigned SampleWidth = 16;
    typedef logic [SampleWidth-1:0] sample_t;

    // Increment that sticks at the all-ones value of a field `width` bits wide (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/audio_sawtooth_monitor_if.sv
// Stereo sample stream tapped by the sawtooth monitor.
// The source drives the master modport; the monitor listens on the slave modport.
interface audio_sawtooth_monitor_if #(
    parameter int unsigned AUDIO_BIT_WIDTH = 16
);
    logic                       sample_valid;
    logic [AUDIO_BIT_WIDTH-1:0] audio_sample_word [1:0];

    modport master (
        output sample_valid,
        output audio_sample_word
    );

    modport slave (
        input sample_valid,
        input audio_sample_word
    );
endinterface

// File: rtl/audio_period_meter.sv
// Measures the sawtooth period in samples between consecutive locked wraps.
// The partial period that ends at the first wrap after (re)lock is discarded.
module audio_period_meter
    import audio_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = 16
) (
    input  logic                    clk_audio,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    count_en,
    input  logic                    wrap,
    output logic [PERIOD_WIDTH-1:0] period_samples,
    output logic                    period_valid
);

    logic [PERIOD_WIDTH-1:0] count_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic                    first_wrap_q;
    logic                    period_valid_q;

    always_ff @(posedge clk_audio or negedge rst_n) begin
        if (!rst_n) begin
            count_q        <= '0;
            period_q       <= '0;
            first_wrap_q   <= 1'b0;
            period_valid_q <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            if (clear) begin
                count_q      <= '0;
                first_wrap_q <= 1'b1;
            end else if (count_en) begin
                if (wrap) begin
                    count_q      <= '0;
                    first_wrap_q <= 1'b0;
                    if (!first_wrap_q) begin
                        period_q       <= PERIOD_WIDTH'(sat_inc(32'(count_q), PERIOD_WIDTH));
                        period_valid_q <= 1'b1;
                    end
                end else begin
                    count_q <= PERIOD_WIDTH'(sat_inc(32'(count_q), PERIOD_WIDTH));
                end
            end
        end
    end

    assign period_samples = period_q;
    assign period_valid   = period_valid_q;

endmodule

// File: rtl/audio_sawtooth_monitor.sv
// Receive-side sawtooth checker: learns the per-sample delta, locks, counts deviations.
// Optional stereo agreement check enabled by AUDIO_SAWTOOTH_MON_STEREO_CHECK_EN.
module audio_sawtooth_monitor
    import audio_pkg::*;
#(
    parameter int unsigned AUDIO_BIT_WIDTH = 16,
    parameter int unsigned CHANNEL         = 1,
    parameter int unsigned LOCK_COUNT      = 4,
    parameter int unsigned PERIOD_WIDTH    = 16,
    parameter int unsigned ERR_WIDTH       = 16
) (
    input  logic                       clk_audio,
    input  logic                       rst_n,
    audio_sawtooth_monitor_if.slave    stream,
    output logic                       locked,
    output logic [AUDIO_BIT_WIDTH-1:0] increment,
    output logic [PERIOD_WIDTH-1:0]    period_samples,
    output logic                       period_valid,
    output logic                       wrap_pulse,
    output logic [ERR_WIDTH-1:0]       error_count,
    output logic                       chan_mismatch
);

    localparam logic ChanSel = 1'(CHANNEL);

    mon_state_t                 state_q;
    logic [AUDIO_BIT_WIDTH-1:0] prev_q;
    logic [AUDIO_BIT_WIDTH-1:0] inc_q;
    logic [3:0]                 match_cnt_q;
    logic                       locked_q;
    logic                       wrap_q;
    logic [ERR_WIDTH-1:0]       err_q;

    logic [AUDIO_BIT_WIDTH-1:0] cur;
    logic [AUDIO_BIT_WIDTH-1:0] delta;
    logic                       delta_match;
    logic                       lock_hit;
    logic                       meter_clear;
    logic                       meter_count;
    logic                       meter_wrap;

    assign cur         = stream.audio_sample_word[ChanSel];
    assign delta       = cur - prev_q;
    assign delta_match = (delta == inc_q);
    assign lock_hit    = (match_cnt_q == 4'(LOCK_COUNT - 1));

    // Meter controls decode the current sample so the meter's outputs align with ours.
    assign meter_clear = stream.sample_valid && (state_q == StTrain) && delta_match && lock_hit;
    assign meter_count = stream.sample_valid && (state_q == StLocked) && delta_match;
    assign meter_wrap  = meter_count && (cur < prev_q);

    always_ff @(posedge clk_audio or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            prev_q      <= '0;
            inc_q       <= '0;
            match_cnt_q <= '0;
            locked_q    <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            wrap_q <= 1'b0;
            if (stream.sample_valid) begin
                prev_q <= cur;
                case (state_q)
                    StEmpty: state_q <= StLearn;
                    StLearn: begin
                        if (delta != '0) begin
                            inc_q       <= delta;
                            match_cnt_q <= '0;
                            state_q     <= StTrain;
                        end
                    end
                    StTrain: begin
                        if (delta_match) begin
                            match_cnt_q <= match_cnt_q + 4'd1;
                            if (lock_hit) begin
                                state_q  <= StLocked;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            inc_q       <= delta;
                            match_cnt_q <= '0;
                            if (delta == '0) state_q <= StLearn;
                        end
                    end
                    StLocked: begin
                        if (delta_match) begin
                            wrap_q <= meter_wrap;
                        end else begin
                            // A mismatch overrides any wrap on the same sample.
                            err_q       <= ERR_WIDTH'(sat_inc(32'(err_q), ERR_WIDTH));
                            locked_q    <= 1'b0;
                            inc_q       <= delta;
                            match_cnt_q <= '0;
                            state_q     <= (delta == '0) ? StLearn : StTrain;
                        end
                    end
                    default: state_q <= StEmpty;
                endcase
            end
        end
    end

    audio_period_meter #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_period_meter (
        .clk_audio      (clk_audio),
        .rst_n          (rst_n),
        .clear          (meter_clear),
        .count_en       (meter_count),
        .wrap           (meter_wrap),
        .period_samples (period_samples),
        .period_valid   (period_valid)
    );

`ifdef AUDIO_SAWTOOTH_MON_STEREO_CHECK_EN
    logic chan_mismatch_q;

    always_ff @(posedge clk_audio or negedge rst_n) begin
        if (!rst_n) begin
            chan_mismatch_q <= 1'b0;
        end else if (stream.sample_valid &&
                     (stream.audio_sample_word[0] != stream.audio_sample_word[1])) begin
            chan_mismatch_q <= 1'b1;
        end
    end

    assign chan_mismatch = chan_mismatch_q;
`else
    assign chan_mismatch = 1'b0;
`endif

    assign locked      = locked_q;
    assign increment   = inc_q;
    assign wrap_pulse  = wrap_q;
    assign error_count = err_q;

endmodule

// File: tb/tb_audio_sawtooth_monitor.sv
// Directed bench for audio_sawtooth_monitor with a queue-based scoreboard fed by a
// behavioural model; honours AUDIO_SAWTOOTH_MON_STEREO_CHECK_EN when defined.
module tb_audio_sawtooth_monitor;
    import audio_pkg::*;

    localparam int unsigned Chan = 1;
    localparam int unsigned Lock = 4;
    localparam sample_t     Step = 16'd655;
`ifdef AUDIO_SAWTOOTH_MON_STEREO_CHECK_EN
    localparam bit Stereo = 1'b1;
`else
    localparam bit Stereo = 1'b0;
`endif

    typedef struct packed {
        logic        locked;
        logic [15:0] increment;
        logic [15:0] period;
        logic        pv;
        logic        wrap;
        logic [15:0] err;
        logic        chan;
    } obs_t;

    logic        clk_audio;
    logic        rst_n;
    logic        locked;
    logic [15:0] increment;
    logic [15:0] period_samples;
    logic        period_valid;
    logic        wrap_pulse;
    logic [15:0] error_count;
    logic        chan_mismatch;

    audio_sawtooth_monitor_if #(.AUDIO_BIT_WIDTH(16)) stream_if ();

    audio_sawtooth_monitor #(
        .AUDIO_BIT_WIDTH (16),
        .CHANNEL         (Chan),
        .LOCK_COUNT      (Lock),
        .PERIOD_WIDTH    (16),
        .ERR_WIDTH       (16)
    ) dut (
        .clk_audio      (clk_audio),
        .rst_n          (rst_n),
        .stream         (stream_if),
        .locked         (locked),
        .increment      (increment),
        .period_samples (period_samples),
        .period_valid   (period_valid),
        .wrap_pulse     (wrap_pulse),
        .error_count    (error_count),
        .chan_mismatch  (chan_mismatch)
    );

    initial clk_audio = 1'b0;
    always #5 clk_audio = ~clk_audio;

    int      total = 0;
    int      bad = 0;
    int      n_step = 0;
    int      wraps, pvs, cont_wraps;
    bit      got_period;
    sample_t first_period;
    sample_t v;
    obs_t    exp_q [$];

    // Reference model state
    int      m_state, m_match;
    sample_t m_prev, m_inc, m_cnt, m_period, m_err;
    logic    m_locked, m_first, m_chan;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_match = 0; m_prev = '0; m_inc = '0; m_cnt = '0;
        m_period = '0; m_err = '0; m_locked = 0; m_first = 0; m_chan = 0;
    endtask

    task automatic model_step(input sample_t c0, input sample_t c1, input logic vld,
                              output obs_t e);
        sample_t cur, d;
        logic    wr, pv;
        wr = 0;
        pv = 0;
        if (vld) begin
            cur = (Chan == 1) ? c1 : c0;
            d   = cur - m_prev;
            case (m_state)
                0: m_state = 1;
                1: if (d != 0) begin m_inc = d; m_match = 0; m_state = 2; end
                2: begin
                    if (d == m_inc) begin
                        m_match++;
                        if (m_match == Lock) begin
                            m_state = 3; m_locked = 1; m_cnt = 0; m_first = 1;
                        end
                    end else begin
                        m_inc = d; m_match = 0;
                        if (d == 0) m_state = 1;
                    end
                end
                default: begin
                    if (d == m_inc) begin
                        if (cur < m_prev) begin
                            wr = 1;
                            if (!m_first) begin
                                m_period = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
                                pv = 1;
                            end
                            m_first = 0;
                            m_cnt = 0;
                        end else if (m_cnt != 16'hFFFF) begin
                            m_cnt++;
                        end
                    end else begin
                        if (m_err != 16'hFFFF) m_err++;
                        m_locked = 0; m_inc = d; m_match = 0;
                        m_state = (d == 0) ? 1 : 2;
                    end
                end
            endcase
            if (Stereo && (c0 != c1)) m_chan = 1;
            m_prev = cur;
        end
        e = '{locked: m_locked, increment: m_inc, period: m_period, pv: pv, wrap: wr,
              err: m_err, chan: m_chan};
    endtask

    task automatic step(input sample_t c0, input sample_t c1, input logic vld);
        obs_t e, o;
        stream_if.sample_valid         = vld;
        stream_if.audio_sample_word[0] = c0;
        stream_if.audio_sample_word[1] = c1;
        model_step(c0, c1, vld, e);
        exp_q.push_back(e);
        @(posedge clk_audio);
        #1;
        n_step++;
        o = '{locked: locked, increment: increment, period: period_samples, pv: period_valid,
              wrap: wrap_pulse, err: error_count, chan: chan_mismatch};
        e = exp_q.pop_front();
        chk($sformatf("sb#%0d", n_step), 64'(o), 64'(e));
        if (wrap_pulse) wraps++;
        if (period_valid) begin
            pvs++;
            if (!got_period) begin
                got_period   = 1;
                first_period = period_samples;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stream_if.sample_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_audio);
        #1;
        rst_n = 1'b1;
        wraps = 0; pvs = 0; got_period = 0; first_period = '0; v = '0;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({locked, increment, period_samples, period_valid, wrap_pulse,
                    error_count, chan_mismatch});
    endfunction

    initial begin
        rst_n = 1'b0;
        stream_if.sample_valid = 1'b0;
        stream_if.audio_sample_word[0] = '0;
        stream_if.audio_sample_word[1] = '0;
        model_reset();
        #12;
        chk("reset_outputs", all_outs(), 64'd0);
        do_reset();

        // Ideal sawtooth, continuous valid
        for (int k = 1; k <= 320; k++) begin
            step(v, v, 1'b1);
            if (k == 5) chk("lock_before_6", 64'(locked), 64'd0);
            if (k == 6) chk("lock_at_6", 64'(locked), 64'd1);
            v += Step;
        end
        chk("increment", 64'(increment), 64'(Step));
        chk("wrap_count", 64'(wraps), 64'd3);
        chk("period_valid_count", 64'(pvs), 64'd2);
        chk("first_period_range", 64'((first_period == 16'd100) || (first_period == 16'd101)),
            64'd1);
        chk("no_errors", 64'(error_count), 64'd0);
        cont_wraps = wraps;

        // Single glitch while locked, then relock
        step(16'h1234, 16'h1234, 1'b1);
        chk("glitch_unlock", 64'(locked), 64'd0);
        chk("glitch_err", 64'(error_count), 64'd1);
        for (int k = 1; k <= 6; k++) begin
            step(v, v, 1'b1);
            if (k == 5) chk("relock_pending", 64'(locked), 64'd0);
            v += Step;
        end
        chk("relock", 64'(locked), 64'd1);
        chk("relock_inc", 64'(increment), 64'(Step));
        chk("err_persist", 64'(error_count), 64'd1);

        // Valid toggling with junk on invalid cycles
        do_reset();
        for (int k = 1; k <= 320; k++) begin
            step(v, v, 1'b1);
            if (k == 6) chk("toggle_lock_at_6", 64'(locked), 64'd1);
            step(sample_t'($urandom), sample_t'($urandom), 1'b0);
            v += Step;
        end
        chk("toggle_wraps", 64'(wraps), 64'(cont_wraps));
        chk("toggle_pvs", 64'(pvs), 64'd2);

        // Constant zero never locks
        do_reset();
        for (int k = 0; k < 200; k++) step(16'h0000, 16'h0000, 1'b1);
        chk("const_locked", 64'(locked), 64'd0);
        chk("const_err", 64'(error_count), 64'd0);
        chk("const_wraps", 64'(wraps), 64'd0);
        chk("const_inc", 64'(increment), 64'd0);

        // Reset asserted mid-lock after period and error have been recorded
        do_reset();
        for (int k = 1; k <= 210; k++) begin step(v, v, 1'b1); v += Step; end
        step(16'h1234, 16'h1234, 1'b1);
        for (int k = 1; k <= 6; k++) begin step(v, v, 1'b1); v += Step; end
        chk("prereset_period", 64'(period_samples), 64'd100);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_reset_outputs", all_outs(), 64'd0);
        repeat (3) @(posedge clk_audio);
        #1;
        rst_n = 1'b1;
        v = '0;
        for (int k = 1; k <= 6; k++) begin
            step(v, v, 1'b1);
            if (k == 5) chk("post_reset_lock_pending", 64'(locked), 64'd0);
            v += Step;
        end
        chk("post_reset_lock", 64'(locked), 64'd1);
        chk("post_reset_inc", 64'(increment), 64'(Step));

        // Channel 0 held at zero, channel 1 sawtooth
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(16'h0000, v, 1'b1);
            if (k == 1) chk("chan_first", 64'(chan_mismatch), 64'd0);
            if (k >= 2) chk($sformatf("chan_%0d", k), 64'(chan_mismatch), 64'(Stereo));
            v += Step;
        end
        chk("stereo_lock", 64'(locked), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_sawtooth_monitor.md
Name: audio_sawtooth_monitor

Overview:
Receive-side checker for the stereo audio sample stream produced by the test-tone generators in the sound library.
- Sits on the clk_audio domain next to the audio packetizer input and taps audio_sample_word.
- Learns the per-sample increment of a sawtooth, locks onto it and counts deviations.
- Measures the waveform period in samples, so HDMI audio bring-up is checked in hardware rather than by listening.

Parameters:
AUDIO_BIT_WIDTH, 16, sample word width
CHANNEL, 1, index (0/1) of the audio_sample_word element being monitored
LOCK_COUNT, 4, consecutive matching deltas needed to assert locked (range 1..15)
PERIOD_WIDTH, 16, width of the period counter and period_samples
ERR_WIDTH, 16, width of the saturating error counter

Ports:
clk_audio  input  1  audio sample clock
rst_n  input  1  asynchronous active-low reset
sample_valid  input  1  qualifies audio_sample_word this cycle; tie 1 for one-sample-per-clock sources
audio_sample_word  input  [AUDIO_BIT_WIDTH-1:0] x [1:0]  stereo sample, unpacked array
locked  output  1  high while tracking a consistent sawtooth
increment  output  AUDIO_BIT_WIDTH  learned per-sample delta
period_samples  output  PERIOD_WIDTH  last full period length, in samples
period_valid  output  1  one-cycle pulse when period_samples updates
wrap_pulse  output  1  one-cycle pulse on a locked wrap-around sample
error_count  output  ERR_WIDTH  saturating count of mismatches while locked
chan_mismatch  output  1  sticky channel disagreement flag (optional feature)

Behaviour:
- Reset (async assert, sync release): state EMPTY; all outputs 0; prev, match_cnt and period counter cleared.
- Only cycles with sample_valid=1 advance state. Cycles with sample_valid=0 hold all state, and all pulses are 0.
- Let cur = audio_sample_word[CHANNEL]. Then delta = cur - prev, modulo 2^AUDIO_BIT_WIDTH (unsigned wrap). prev <= cur on every valid sample.
- All outputs are registered, with one-cycle latency after the valid sample that causes them.
- EMPTY: first valid sample loads prev only -> LEARN.
- LEARN:
  - delta==0: stay in LEARN. A constant signal never locks.
  - Otherwise: increment <= delta, match_cnt <= 0 -> TRAIN.
- TRAIN:
  - delta==increment: match_cnt++. When match_cnt reaches LOCK_COUNT -> LOCKED, locked <= 1, period counter <= 0, first_wrap <= 1.
  - delta!=increment: increment <= delta, match_cnt <= 0. If delta==0 -> LEARN.
- LOCKED, delta==increment:
  - Period counter increments, saturating at all-ones.
  - If cur < prev (unsigned), the sample is a wrap: wrap_pulse=1 and the counter restarts at 0.
  - On a wrap, if first_wrap=0: period_samples <= counter+1 (saturating), and period_valid pulses. The first wrap after lock only clears first_wrap, because that period is partial.
- LOCKED, delta!=increment:
  - error_count++ (saturating at all-ones); locked <= 0.
  - increment <= delta, match_cnt <= 0 -> TRAIN (or LEARN if delta==0).
  - No wrap_pulse is raised for this sample.
- A wrap and a mismatch on the same sample: the mismatch wins.
- error_count and period_samples persist across relock. Only rst_n clears them.

Optional Feature:
- Macro: AUDIO_SAWTOOTH_MON_STEREO_CHECK_EN.
- Defined: on every valid sample, if audio_sample_word[0] != audio_sample_word[1], chan_mismatch is set to 1. The flag is sticky until rst_n.
- Undefined: chan_mismatch is driven constant 0 and no comparator logic is present.

Decomposition:
- audio_pkg holds:
  - mon_state_t enum {EMPTY, LEARN, TRAIN, LOCKED};
  - the sample_t typedef parameterised by width;
  - the saturating-increment function.
- Sub-module audio_period_meter contains the period counter, first_wrap, period_samples and period_valid.
  - Inputs: clear, count_en, wrap.
  - The top-level FSM drives it.

Test Plan:
- Ideal sawtooth (W=16, increment 655 per sample, continuous valid) -> locked rises after 1+1+4 valid samples + 1 cycle; increment==655; wrap_pulse every 100 or 101 samples; first period_valid at the second wrap with period_samples in {100,101}; error_count==0.
- Inject a single glitch sample 0x1234 while locked -> locked falls next cycle; error_count==1; relock after LOCK_COUNT matches; increment back to 655.
- sample_valid toggled 1/0 every cycle with the same sample sequence -> identical outputs to the continuous case, stretched 2x; no pulses on invalid cycles.
- Constant input 0x0000 for 200 samples -> stays in LEARN; locked=0; error_count=0; no wrap_pulse.
- Assert rst_n low mid-lock for 3 cycles -> all outputs 0 immediately on assertion; after release, relock exactly as in the ideal case.
- With AUDIO_SAWTOOTH_MON_STEREO_CHECK_EN, channel 0 held at 0 and channel 1 sawtooth -> chan_mismatch=1 from the second valid sample and stays 1. Without the macro -> chan_mismatch=0.
